// File: rtl/cmd_router.sv
// cmd_router: framed command parser that checks, buffers and routes payloads to one of NUM_DEST channels
module cmd_router #(
  parameter int DATA_W = 8,
  parameter int NUM_DEST = 8,
  parameter logic [DATA_W-1:0] PREFIX = 8'hAA,
  parameter logic [DATA_W-1:0] ADDR_SELF = 8'h01,
  parameter int BUF_DEPTH = 256,
  parameter int CHK_MODE = 0,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic n_rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic rx_valid,
  output logic rx_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [NUM_DEST-1:0] out_valid,
  input  logic [NUM_DEST-1:0] out_ready,
  output logic pkt_ok,
  output logic err_chk,
  output logic err_dest,
  output logic err_timeout,
  output logic busy
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC);
  typedef enum logic [2:0] {S_PREFIX, S_ADDR, S_DEST, S_LEN, S_DATA, S_CHK, S_FWD} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] fill;
  logic [DATA_W-1:0] dest, len, cnt, acc, acc_nxt;
  logic [TW-1:0] tcnt;
  logic ovf, dest_bad, chk_bad, accept, xfer, fwd_on, wr_en, tout;
  assign rx_ready = state != S_FWD;
  assign busy = state != S_PREFIX;
  assign accept = rx_valid & rx_ready;
  assign fwd_on = state == S_FWD && fill != '0;
  assign out_valid = fwd_on ? NUM_DEST'(1) << dest : '0;
  assign out_data = fwd_on ? mem[rd_ptr] : '0;
  assign xfer = |(out_valid & out_ready);
  assign dest_bad = {1'b0, dest} >= (DATA_W+1)'(NUM_DEST);
  assign chk_bad = rx_data != acc || ovf;
  assign acc_nxt = CHK_MODE == 1 ? acc ^ rx_data : acc + rx_data;
  assign wr_en = state == S_DATA && accept && fill != (AW+1)'(BUF_DEPTH);
  assign tout = state != S_PREFIX && state != S_FWD && !accept && tcnt == TW'(TIMEOUT_CYC-2);
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= rx_data;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= S_PREFIX;
      {wr_ptr, rd_ptr, fill} <= '0;
      dest <= '0;
      len <= '0;
      cnt <= '0;
      acc <= '0;
      tcnt <= '0;
      ovf <= 1'b0;
      {pkt_ok, err_chk, err_dest, err_timeout} <= '0;
    end else begin
      {pkt_ok, err_chk, err_dest, err_timeout} <= '0;
      tcnt <= (state == S_PREFIX || state == S_FWD || accept) ? '0 : tcnt + 1'b1;
      if (tout) begin
        err_timeout <= 1'b1;
        state <= S_PREFIX;
        acc <= '0;
        {wr_ptr, rd_ptr, fill} <= '0;
      end else if (accept)
        case (state)
          S_PREFIX: state <= rx_data == PREFIX ? S_ADDR : S_PREFIX;
          S_ADDR: state <= rx_data == ADDR_SELF ? S_DEST : S_PREFIX;
          S_DEST: begin
            dest <= rx_data;
            state <= S_LEN;
          end
          S_LEN: begin
            len <= rx_data;
            cnt <= '0;
            acc <= '0;
            ovf <= 1'b0;
            state <= rx_data == '0 ? S_CHK : S_DATA;
          end
          S_DATA: begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            state <= cnt == len - 1'b1 ? S_CHK : S_DATA;
            if (wr_en) begin
              wr_ptr <= wr_ptr + 1'b1;
              fill <= fill + 1'b1;
            end else ovf <= 1'b1;
          end
          S_CHK: begin
            state <= (chk_bad || dest_bad || len == '0) ? S_PREFIX : S_FWD;
            err_chk <= chk_bad;
            err_dest <= !chk_bad && dest_bad;
            pkt_ok <= !chk_bad && !dest_bad && len == '0;
            if (chk_bad || dest_bad) {wr_ptr, rd_ptr, fill} <= '0;
          end
          default: ;
        endcase
      else if (xfer) begin
        rd_ptr <= rd_ptr + 1'b1;
        fill <= fill - 1'b1;
        if (fill == (AW+1)'(1)) begin
          state <= S_PREFIX;
          pkt_ok <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_cmd_router.sv
// tb_cmd_router: directed self-checking bench for cmd_router in sum and xor check modes
module tb_cmd_router;
  logic clk, n_rst;
  logic [7:0] rd0, rd1, od0, od1;
  logic rv0, rv1, rr0, rr1;
  logic [7:0] ov0, ov1, or0, or1;
  logic pk0, ec0, ed0, et0, bz0;
  logic pk1, ec1, ed1, et1, bz1;
  int total, bad;
  int n_ok, n_chk, n_dest, n_to, nrdy, n1_ok, n1_chk;
  logic [7:0] vmask;
  logic busy_s, to_s;
  logic [7:0] got[$], got1[$], fq[$];
  cmd_router #(.TIMEOUT_CYC(20)) u0 (
    .clk(clk), .n_rst(n_rst), .rx_data(rd0), .rx_valid(rv0), .rx_ready(rr0),
    .out_data(od0), .out_valid(ov0), .out_ready(or0), .pkt_ok(pk0), .err_chk(ec0),
    .err_dest(ed0), .err_timeout(et0), .busy(bz0)
  );
  cmd_router #(.CHK_MODE(1), .TIMEOUT_CYC(20)) u1 (
    .clk(clk), .n_rst(n_rst), .rx_data(rd1), .rx_valid(rv1), .rx_ready(rr1),
    .out_data(od1), .out_valid(ov1), .out_ready(or1), .pkt_ok(pk1), .err_chk(ec1),
    .err_dest(ed1), .err_timeout(et1), .busy(bz1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] g0(input int i);
    return i < got.size() ? got[i] : 8'hEE;
  endfunction
  function automatic logic [7:0] g1(input int i);
    return i < got1.size() ? got1[i] : 8'hEE;
  endfunction
  task automatic clr;
    got.delete();
    got1.delete();
    {n_ok, n_chk, n_dest, n_to, nrdy, n1_ok, n1_chk} = '0;
    vmask = '0;
  endtask
  task automatic step;
    @(negedge clk);
    if (|(ov0 & or0)) got.push_back(od0);
    if (|(ov1 & or1)) got1.push_back(od1);
    vmask |= ov0;
    n_ok += int'(pk0);
    n_chk += int'(ec0);
    n_dest += int'(ed0);
    n_to += int'(et0);
    nrdy += int'(!rr0);
    n1_ok += int'(pk1);
    n1_chk += int'(ec1);
    busy_s = bz0;
    to_s = et0;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int w, input logic [7:0] d);
    if (w == 0) begin
      rv0 = 1'b1;
      rd0 = d;
    end else begin
      rv1 = 1'b1;
      rd1 = d;
    end
    step();
    rv0 = 1'b0;
    rv1 = 1'b0;
  endtask
  task automatic sendq(input int w);
    foreach (fq[i]) send(w, fq[i]);
  endtask
  task automatic drain;
    int i = 0;
    do begin
      step();
      i++;
    end while (busy_s && i < 100);
    chk("drain_idle", busy_s, 1'b0);
  endtask
  initial begin
    int at;
    logic at_busy;
    logic rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    clk = 0;
    n_rst = 0;
    {rv0, rv1, rd0, rd1} = '0;
    or0 = 8'hFF;
    or1 = 8'hFF;
    total = 0;
    bad = 0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rx_ready", rr0, 1'b1);
    chk("rst_busy", bz0, 1'b0);
    chk("rst_out_valid", ov0, 8'h00);
    chk("rst_out_data", od0, 8'h00);
    chk("rst_pulses", {pk0, ec0, ed0, et0}, 4'h0);
    n_rst = 1;
    step();
    clr();
    fq = '{8'hAA, 8'h01, 8'h03, 8'h02, 8'h10, 8'h20, 8'h30};
    sendq(0);
    chk("t1_lat_valid", ov0, 8'h08);
    chk("t1_lat_data", od0, 8'h10);
    chk("t1_fwd_rx_ready", rr0, 1'b0);
    drain();
    chk("t1_count", got.size(), 2);
    chk("t1_d0", g0(0), 8'h10);
    chk("t1_d1", g0(1), 8'h20);
    chk("t1_pkt_ok", n_ok, 1);
    chk("t1_vmask", vmask, 8'h08);
    chk("t1_not_ready_cycles", nrdy, 2);
    clr();
    fq = '{8'hAA, 8'h01, 8'h03, 8'h02, 8'h10, 8'h20, 8'h31};
    sendq(0);
    drain();
    chk("t2_err_chk", n_chk, 1);
    chk("t2_vmask", vmask, 8'h00);
    chk("t2_pkt_ok", n_ok, 0);
    fq = '{8'hAA, 8'h01, 8'h05, 8'h01, 8'h44, 8'h44};
    sendq(0);
    drain();
    chk("t2_next_count", got.size(), 1);
    chk("t2_next_d0", g0(0), 8'h44);
    chk("t2_next_vmask", vmask, 8'h20);
    clr();
    fq = '{8'h55, 8'hAA, 8'h07, 8'hAA, 8'h01, 8'h02, 8'h01, 8'h66, 8'h66};
    sendq(0);
    drain();
    chk("t3_d0", g0(0), 8'h66);
    chk("t3_vmask", vmask, 8'h04);
    chk("t3_no_errors", n_chk + n_dest + n_to, 0);
    chk("t3_pkt_ok", n_ok, 1);
    clr();
    fq = '{8'hAA, 8'h01, 8'h09, 8'h01, 8'h05, 8'h05};
    sendq(0);
    drain();
    chk("t4_err_dest", n_dest, 1);
    chk("t4_err_chk", n_chk, 0);
    chk("t4_vmask", vmask, 8'h00);
    fq = '{8'hAA, 8'h01, 8'h09, 8'h01, 8'h05, 8'h06};
    sendq(0);
    drain();
    chk("t4_both_err_chk", n_chk, 1);
    chk("t4_both_err_dest", n_dest, 1);
    clr();
    fq = '{8'hAA, 8'h01, 8'h00, 8'h04, 8'h11};
    sendq(0);
    at = -1;
    at_busy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (to_s && at < 0) begin
        at = i;
        at_busy = busy_s;
      end
    end
    chk("t5_timeout_cycle", at, 19);
    chk("t5_timeout_busy", at_busy, 1'b0);
    chk("t5_timeout_count", n_to, 1);
    fq = '{8'hAA, 8'h01, 8'h00, 8'h02, 8'h12, 8'h34, 8'h46};
    sendq(0);
    drain();
    chk("t5_next_count", got.size(), 2);
    chk("t5_next_d0", g0(0), 8'h12);
    chk("t5_next_d1", g0(1), 8'h34);
    chk("t5_next_vmask", vmask, 8'h01);
    chk("t5_next_err_chk", n_chk, 0);
    clr();
    fq = '{8'hAA, 8'h01, 8'h03, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h16};
    sendq(0);
    for (int i = 0; i < 5; i++) begin
      or0 = rdy[i] ? 8'hFF : 8'h00;
      if (i == 1 || i == 2) begin
        chk("t6_hold_data", od0, 8'hB2);
        chk("t6_hold_valid", ov0, 8'h08);
      end
      step();
    end
    or0 = 8'hFF;
    drain();
    chk("t6_count", got.size(), 3);
    chk("t6_d0", g0(0), 8'hA1);
    chk("t6_d1", g0(1), 8'hB2);
    chk("t6_d2", g0(2), 8'hC3);
    chk("t6_pkt_ok", n_ok, 1);
    clr();
    fq = '{8'hAA, 8'h01, 8'h02, 8'h00, 8'h00};
    sendq(0);
    drain();
    chk("t7_len0_pkt_ok", n_ok, 1);
    chk("t7_len0_vmask", vmask, 8'h00);
    chk("t7_len0_err", n_chk + n_dest, 0);
    clr();
    fq = '{8'hAA, 8'h01, 8'h00, 8'h02, 8'hF0, 8'h0F, 8'hFF};
    sendq(1);
    repeat (4) step();
    fq = '{8'hAA, 8'h01, 8'h01, 8'h02, 8'h0F, 8'h0F, 8'h00};
    sendq(1);
    repeat (4) step();
    chk("t8_xor_pkt_ok", n1_ok, 2);
    chk("t8_xor_err_chk", n1_chk, 0);
    chk("t8_xor_count", got1.size(), 4);
    chk("t8_xor_d0", g1(0), 8'hF0);
    chk("t8_xor_d1", g1(1), 8'h0F);
    chk("t8_xor_d2", g1(2), 8'h0F);
    clr();
    or0 = 8'h00;
    fq = '{8'hAA, 8'h01, 8'h03, 8'h01, 8'h77, 8'h77};
    sendq(0);
    step();
    chk("t9_stall_valid", ov0, 8'h08);
    n_rst = 0;
    #1;
    chk("t9_rst_valid", ov0, 8'h00);
    chk("t9_rst_data", od0, 8'h00);
    chk("t9_rst_busy", bz0, 1'b0);
    chk("t9_rst_ready", rr0, 1'b1);
    @(posedge clk);
    #1;
    n_rst = 1;
    or0 = 8'hFF;
    clr();
    fq = '{8'hAA, 8'h01, 8'h04, 8'h01, 8'h5A, 8'h5A};
    sendq(0);
    drain();
    chk("t9_after_count", got.size(), 1);
    chk("t9_after_d0", g0(0), 8'h5A);
    chk("t9_after_vmask", vmask, 8'h10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cmd_router.md
Name: cmd_router

Overview:
- Parametrised packet decoder/router for the host byte link.
- Parses framed commands of the form PREFIX, ADDR, DEST, LEN, LEN payload words, CHECK.
- Buffers the payload, verifies the check word, then forwards the payload to one of NUM_DEST downstream channels with valid/ready handshake.
- Adds rx backpressure, a selectable check mode, bad-destination rejection, synchronous timeout abort and error/status pulses.

Parameters:
- DATA_W, 8, link and payload word width.
- NUM_DEST, 8, number of downstream channels (1..2**DATA_W).
- PREFIX, 8'hAA, frame start word (DATA_W bits).
- ADDR_SELF, 8'h01, this node's address; other addresses are ignored.
- BUF_DEPTH, 256, payload buffer depth in words; power of 2, must be >= max LEN.
- CHK_MODE, 0, check algorithm: 0 = modulo-2**DATA_W sum of payload, 1 = XOR of payload.
- TIMEOUT_CYC, 50000, idle cycles mid-frame before abort (>= 2).

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- rx_data  in  DATA_W  incoming word
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  word accepted when rx_valid & rx_ready
- out_data  out  DATA_W  payload word to the selected channel
- out_valid  out  NUM_DEST  one-hot valid; bit = latched DEST
- out_ready  in  NUM_DEST  per-channel ready
- pkt_ok  out  1  1-cycle pulse when a frame is fully forwarded
- err_chk  out  1  1-cycle pulse on check mismatch
- err_dest  out  1  1-cycle pulse on DEST >= NUM_DEST
- err_timeout  out  1  1-cycle pulse on timeout abort
- busy  out  1  high whenever state != S_PREFIX

Behaviour:
- Reset: state = S_PREFIX, buffer empty, accumulator = 0, all out_valid = 0, pulses = 0, out_data = 0. rx_ready is 1 after reset.
- Clocking and reset:
  - All logic is clocked on clk.
  - n_rst is the only asynchronous reset.
  - Timeout abort is synchronous; it never drives an async reset input.
- Accept = rx_valid & rx_ready. The state advances only on accept, except in S_FWD.
- rx_ready is 1 in S_PREFIX, S_ADDR, S_DEST, S_LEN, S_DATA and S_CHK; it is 0 in S_FWD.
- State machine:
  - S_PREFIX: word == PREFIX -> S_ADDR; otherwise stay.
  - S_ADDR: word == ADDR_SELF -> S_DEST; otherwise -> S_PREFIX (no error pulse).
  - S_DEST: latch dest -> S_LEN. A dest >= NUM_DEST is still latched and flagged bad.
  - S_LEN: latch len and clear cnt and accumulator. len == 0 -> S_CHK; otherwise -> S_DATA.
  - S_DATA: write the word to the buffer and update the accumulator (sum or XOR, truncated to DATA_W). cnt == len-1 -> S_CHK; otherwise cnt += 1.
  - S_CHK: compare the word with the accumulator.
    - Match and dest good -> S_FWD; if len == 0, pulse pkt_ok instead and go to S_PREFIX.
    - Mismatch -> pulse err_chk, clear the buffer, go to S_PREFIX.
    - Match but dest bad -> pulse err_dest, clear the buffer, go to S_PREFIX.
    - If both mismatch and bad dest occur, only err_chk pulses.
  - S_FWD: present the buffer head.
    - out_valid[dest] = 1 while the buffer is non-empty; out_data = buffer head.
    - Transfer = out_valid[dest] & out_ready[dest]; on transfer, pop one word.
    - When the last word transfers: out_valid drops the next cycle, pkt_ok pulses that same cycle, state -> S_PREFIX.
    - out_data and out_valid hold stable while out_ready is low.
    - out_valid bits other than dest are always 0.
- Buffer:
  - Show-ahead FIFO, depth BUF_DEPTH.
  - Writes occur only in S_DATA; reads only in S_FWD, so no simultaneous read/write.
  - len > BUF_DEPTH is illegal configuration and untested; the design must not wrap silently. Overflow words are dropped and the frame ends with err_chk.
- Timeout:
  - Counter clears on accept and in S_PREFIX and S_FWD; otherwise it increments.
  - When it reaches TIMEOUT_CYC-1: pulse err_timeout, clear the buffer and accumulator, go to S_PREFIX. The counter clears the following cycle.
  - S_FWD is never timed out; downstream stall is legal.
- Latency: the first out_valid is asserted the cycle after the check word is accepted.
- Back-to-back frames: a new PREFIX is accepted on the cycle after S_FWD exits.
- Reset mid-operation: n_rst low immediately returns all state and outputs to their reset values and empties the buffer.

Test Plan:
- Frame AA 01 03 02 10 20 | check 30 (CHK_MODE=0), out_ready = 1 -> out_valid = 8'b0000_1000, data 10 then 20 on consecutive cycles, pkt_ok 1 cycle later, rx_ready low only during S_FWD.
- Same frame with check 31 -> err_chk pulse, no out_valid, the next good frame forwards correctly (buffer was cleared).
- Garbage 55 AA 07 AA 01 ... (wrong address 07) -> silently resynchronises; the following valid frame is routed, no error pulses.
- DEST = 09 with NUM_DEST = 8 and a correct check -> err_dest pulse, all out_valid stay 0.
- Header AA 01 00 04 11, then rx_valid low for TIMEOUT_CYC cycles -> err_timeout pulse at cycle TIMEOUT_CYC-1, busy = 0; a subsequent good frame is forwarded intact.
- Forward with out_ready[dest] toggling 1,0,0,1 and with len = 0 -> data held stable while ready is low, no loss or duplication. len = 0 with check 00 -> pkt_ok and no out_valid. CHK_MODE=1 with payload F0 0F and check FF -> accepted.
